// File: rtl/if_id_tracker_pkg.sv
// Shared trace record types for the IF/ID trace tracker.
// Holds the emitted record layout, the IF half-record and both FSM encodings.
`timescale 1ns/1ps
package ryuki_datatypes;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] if_start;
        logic [31:0] if_end;
        logic [31:0] id_start;
        logic [31:0] id_end;
    } trace_output;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] if_start;
        logic [31:0] if_end;
    } if_record;

    typedef enum logic {
        IF_IDLE,
        IF_WAIT_RVALID
    } if_state_e;

    typedef enum logic {
        ID_WAIT_DECODE,
        ID_DECODING
    } id_state_e;

    localparam int FIFO_DEPTH = 2;

    function automatic trace_output make_trace(
        input if_record    r,
        input logic [31:0] id_start,
        input logic [31:0] id_end
    );
        trace_output t;
        t.addr     = r.addr;
        t.instr    = r.instr;
        t.if_start = r.if_start;
        t.if_end   = r.if_end;
        t.id_start = id_start;
        t.id_end   = id_end;
        return t;
    endfunction

endpackage

// File: rtl/if_id_tracker_if_tracker.sv
// IF half of the trace record: follows the instruction-memory handshake.
// Ports: clk, rst, counter, instr_req/addr/grant/rvalid/rdata in; if_data_ready, if_data out.
`timescale 1ns/1ps
module if_tracker
    import ryuki_datatypes::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           counter,
    input  logic                  instr_req,
    input  logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic                  instr_grant,
    input  logic                  instr_rvalid,
    input  logic [DATA_WIDTH-1:0] instr_rdata,
    output logic                  if_data_ready,
    output if_record              if_data
);

    if_state_e   state_q;
    if_state_e   state_d;
    logic [31:0] addr_q;
    logic [31:0] start_q;
    logic        start_fetch;
    logic        finish_fetch;

    always_comb begin
        state_d      = state_q;
        start_fetch  = 1'b0;
        finish_fetch = 1'b0;
        unique case (state_q)
            IF_IDLE: begin
                if (instr_req && instr_grant) begin
                    start_fetch = 1'b1;
                    state_d     = IF_WAIT_RVALID;
                end
            end
            IF_WAIT_RVALID: begin
                if (instr_rvalid) begin
                    finish_fetch = 1'b1;
                    // A grant on the rvalid cycle opens the next record at once.
                    if (instr_req && instr_grant) begin
                        start_fetch = 1'b1;
                    end else begin
                        state_d = IF_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IF_IDLE;
            addr_q        <= '0;
            start_q       <= '0;
            if_data_ready <= 1'b0;
            if_data       <= '0;
        end else begin
            state_q       <= state_d;
            if_data_ready <= finish_fetch;
            if (start_fetch) begin
                addr_q  <= 32'(instr_addr);
                start_q <= counter;
            end
            // Output copy is separate so a same-cycle restart cannot corrupt it.
            if (finish_fetch) begin
                if_data.addr     <= addr_q;
                if_data.instr    <= 32'(instr_rdata);
                if_data.if_start <= start_q;
                if_data.if_end   <= counter;
            end
        end
    end

endmodule

// File: rtl/if_id_tracker.sv
// IF/ID trace tracker: queues IF records and closes them with ID timestamps.
// Ports: clk, rst, counter, IF handshake, is_decoding, jump_done in; trace_data_ready, trace_data_o out.
`timescale 1ns/1ps
module if_id_tracker
    import ryuki_datatypes::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           counter,
    input  logic                  if_busy,
    input  logic                  if_ready,
    input  logic                  instr_req,
    input  logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic                  instr_grant,
    input  logic                  instr_rvalid,
    input  logic [DATA_WIDTH-1:0] instr_rdata,
    input  logic                  is_decoding,
    input  logic                  jump_done,
    output logic                  trace_data_ready,
    output trace_output           trace_data_o
);

    logic     if_data_ready;
    if_record if_data;

    if_tracker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_if_tracker (
        .clk           (clk),
        .rst           (rst),
        .counter       (counter),
        .instr_req     (instr_req),
        .instr_addr    (instr_addr),
        .instr_grant   (instr_grant),
        .instr_rvalid  (instr_rvalid),
        .instr_rdata   (instr_rdata),
        .if_data_ready (if_data_ready),
        .if_data       (if_data)
    );

    // IF stage status is informational only; fetches are tracked regardless.
    logic unused_ok;
    assign unused_ok = &{1'b0, if_busy, if_ready};

    if_record    fifo_q [FIFO_DEPTH];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    id_state_e   state_q;
    id_state_e   state_d;
    logic [31:0] id_start_q;
    logic        push;
    logic        pop;
    logic        load_start;
    if_record    head;

    assign head = fifo_q[rd_ptr_q];
    assign pop  = (state_q == ID_DECODING) && (!is_decoding || jump_done);
    // A full FIFO still accepts a record when the head leaves on the same edge.
    assign push = if_data_ready && ((count_q != 2'(FIFO_DEPTH)) || pop);
    assign count_d = count_q + {1'b0, push} - {1'b0, pop};

    // count_d counts a record arriving this edge, so decode can start on it.
    always_comb begin
        state_d    = state_q;
        load_start = 1'b0;
        unique case (state_q)
            ID_WAIT_DECODE: begin
                if (is_decoding && (count_d != 2'd0)) begin
                    load_start = 1'b1;
                    state_d    = ID_DECODING;
                end
            end
            ID_DECODING: begin
                if (pop) begin
                    if (is_decoding && (count_d != 2'd0)) begin
                        load_start = 1'b1;
                    end else begin
                        state_d = ID_WAIT_DECODE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q[0]        <= '0;
            fifo_q[1]        <= '0;
            rd_ptr_q         <= 1'b0;
            wr_ptr_q         <= 1'b0;
            count_q          <= '0;
            state_q          <= ID_WAIT_DECODE;
            id_start_q       <= '0;
            trace_data_ready <= 1'b0;
            trace_data_o     <= '0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            trace_data_ready <= pop;
            if (load_start) begin
                id_start_q <= counter;
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= if_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q     <= ~rd_ptr_q;
                trace_data_o <= make_trace(head, id_start_q, counter);
            end
        end
    end

endmodule

// File: tb/tb_if_id_tracker.sv
// Self-checking bench for if_id_tracker: queue-based record model plus literal pins.
// Drives directed fetch/decode sequences with an explicitly controlled counter.
`timescale 1ns/1ps
module tb_if_id_tracker;
    import ryuki_datatypes::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] counter;
    logic        if_busy;
    logic        if_ready;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_grant;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        is_decoding;
    logic        jump_done;
    logic        trace_data_ready;
    trace_output trace_data_o;

    always #5 clk = ~clk;

    if_id_tracker #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .counter          (counter),
        .if_busy          (if_busy),
        .if_ready         (if_ready),
        .instr_req        (instr_req),
        .instr_addr       (instr_addr),
        .instr_grant      (instr_grant),
        .instr_rvalid     (instr_rvalid),
        .instr_rdata      (instr_rdata),
        .is_decoding      (is_decoding),
        .jump_done        (jump_done),
        .trace_data_ready (trace_data_ready),
        .trace_data_o     (trace_data_o)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] cnt    = 0;
    trace_output got [$];

    task automatic check(input string name, input logic [191:0] act,
                         input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drv(input logic req, input logic gnt, input logic rv,
                       input logic dec, input logic jmp,
                       input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        counter      = cnt;
        cnt          = cnt + 1;
        instr_req    = req;
        instr_grant  = gnt;
        instr_rvalid = rv;
        is_decoding  = dec;
        jump_done    = jmp;
        instr_addr   = a;
        instr_rdata  = d;
        if_busy      = req;
        if_ready     = rv;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic take(output trace_output r);
        if (got.size() > 0) r = got.pop_front();
        else r = '0;
    endtask

    // Model: one outstanding fetch, records reach the queue one edge after
    // rvalid, queue holds two, head closes on decode fall or jump.
    bit          m_out;
    logic [31:0] m_addr;
    logic [31:0] m_start;
    bit          m_arr_v;
    trace_output m_arr;
    trace_output q [$];
    bit          m_dec;
    logic [31:0] m_ids;
    logic        exp_ready;
    trace_output exp_data;

    initial begin
        trace_output rec;
        bit          arriving;
        trace_output arr;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_out = 0; m_arr_v = 0; m_dec = 0;
                q.delete();
                exp_ready = 1'b0;
                exp_data  = '0;
            end else begin
                arriving = m_arr_v;
                arr      = m_arr;
                m_arr_v  = 0;
                if (m_out && instr_rvalid) begin
                    m_arr = '0;
                    m_arr.addr     = m_addr;
                    m_arr.instr    = instr_rdata;
                    m_arr.if_start = m_start;
                    m_arr.if_end   = counter;
                    m_arr_v = 1;
                    m_out   = 0;
                end
                if (!m_out && instr_req && instr_grant) begin
                    m_out   = 1;
                    m_addr  = instr_addr;
                    m_start = counter;
                end
                exp_ready = 1'b0;
                if (m_dec && (!is_decoding || jump_done)) begin
                    rec = q.pop_front();
                    rec.id_start = m_ids;
                    rec.id_end   = counter;
                    exp_data  = rec;
                    exp_ready = 1'b1;
                    m_dec = 0;
                end
                if (arriving && q.size() < 2) q.push_back(arr);
                if (!m_dec && is_decoding && q.size() > 0) begin
                    m_dec = 1;
                    m_ids = counter;
                end
            end
            #1;
            check("ready", {191'b0, trace_data_ready}, {191'b0, exp_ready});
            check("record", trace_data_o, exp_data);
            if (trace_data_ready) got.push_back(trace_data_o);
        end
    end

    initial begin
        trace_output r;
        trace_output e;
        counter = 0; if_busy = 0; if_ready = 0;
        instr_req = 0; instr_grant = 0; instr_rvalid = 0;
        instr_addr = 0; instr_rdata = 0; is_decoding = 0; jump_done = 0;
        repeat (2) @(negedge clk);
        check("reset_ready", {191'b0, trace_data_ready}, 192'd0);
        check("reset_data", trace_data_o, 192'd0);
        rst = 1'b0;

        // Single fetch: grant 5, rvalid 7, decode 8..9, fall at 10.
        idle(3);
        drv(1, 0, 0, 0, 0, 32'h0000_0bad, 0);
        idle(1);
        drv(1, 1, 0, 0, 0, 32'h0000_1000, 0);
        idle(1);
        drv(0, 0, 1, 0, 0, 0, 32'hdead_beef);
        drv(0, 0, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        idle(3);
        check("single_count", 192'(got.size()), 192'd1);
        take(r);
        e = '{addr: 32'h1000, instr: 32'hdead_beef, if_start: 32'd5,
              if_end: 32'd7, id_start: 32'd8, id_end: 32'd10};
        check("single_rec", r, e);

        // Back-to-back fetch followed by a jump-terminated decode.
        cnt = 100;
        drv(1, 1, 0, 0, 0, 32'h0000_2000, 0);
        drv(1, 1, 1, 0, 0, 32'h0000_2004, 32'h1111_1111);
        drv(0, 0, 1, 1, 0, 0, 32'h2222_2222);
        drv(0, 0, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 1, 1, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        idle(3);
        check("b2b_count", 192'(got.size()), 192'd2);
        take(r);
        e = '{addr: 32'h2000, instr: 32'h1111_1111, if_start: 32'd100,
              if_end: 32'd101, id_start: 32'd102, id_end: 32'd104};
        check("jump_rec", r, e);
        take(r);
        check("b2b_if_start", 192'(r.if_start), 192'd101);
        check("jump_next_id_start", 192'(r.id_start), 192'd104);
        check("b2b_id_end", 192'(r.id_end), 192'd105);

        // Overflow: three fetches queued with decode idle, third dropped.
        cnt = 200;
        drv(1, 1, 0, 0, 0, 32'h0000_3000, 0);
        drv(0, 0, 1, 0, 0, 0, 32'h3333_0000);
        drv(1, 1, 0, 0, 0, 32'h0000_3004, 0);
        drv(0, 0, 1, 0, 0, 0, 32'h3333_0004);
        drv(1, 1, 0, 0, 0, 32'h0000_3008, 0);
        drv(0, 0, 1, 0, 0, 0, 32'h3333_0008);
        idle(2);
        drv(0, 0, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        idle(1);
        drv(0, 0, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        idle(2);
        check("ovf_count", 192'(got.size()), 192'd2);
        take(r);
        check("ovf_first_addr", 192'(r.addr), 192'h3000);
        take(r);
        e = '{addr: 32'h3004, instr: 32'h3333_0004, if_start: 32'd202,
              if_end: 32'd203, id_start: 32'd210, id_end: 32'd211};
        check("ovf_second_rec", r, e);

        // Reset while a fetch waits for rvalid.
        cnt = 300;
        drv(1, 1, 0, 0, 0, 32'h0000_4000, 0);
        idle(1);
        #2 rst = 1'b1;
        #1;
        check("rst_ready_now", {191'b0, trace_data_ready}, 192'd0);
        check("rst_data_now", trace_data_o, 192'd0);
        idle(2);
        rst = 1'b0;
        drv(0, 0, 1, 0, 0, 0, 32'h4444_4444);
        drv(0, 0, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        idle(3);
        check("rst_no_pulse", 192'(got.size()), 192'd0);

        // Counter wrap with the minimum rvalid-to-pulse latency.
        cnt = 32'hffff_fffe;
        drv(1, 1, 0, 0, 0, 32'h0000_5000, 0);
        drv(0, 0, 1, 0, 0, 0, 32'h5555_5555);
        drv(0, 0, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        idle(3);
        check("wrap_count", 192'(got.size()), 192'd1);
        take(r);
        e = '{addr: 32'h5000, instr: 32'h5555_5555, if_start: 32'hffff_fffe,
              if_end: 32'hffff_ffff, id_start: 32'd0, id_end: 32'd1};
        check("wrap_rec", r, e);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
